// File: rtl/serial_paralelo_param.sv
// Serial-to-parallel receiver with comma-based word alignment and lock detection.
// Optional build macro SP_REALIGN_EN: re-align on a misaligned comma while locked.
module serial_paralelo_param #(
  parameter int unsigned      WIDTH      = 8,
  parameter logic [WIDTH-1:0] COM        = WIDTH'(8'hBC),
  parameter int unsigned      LOCK_COUNT = 4
) (
  input  logic             clk_32f,
  input  logic             reset,
  input  logic             data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             active
);

  localparam int unsigned     CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned     ComW    = $clog2(LOCK_COUNT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);
  localparam logic [ComW-1:0] ComFull = ComW'(LOCK_COUNT);

  typedef enum logic [1:0] {StHunt, StAlign, StLocked} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  sr_q, sr_next;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ComW-1:0]   com_cnt_q, com_cnt_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              valid_q, valid_d;
  logic              active_q;
  logic              match, boundary;

  always_comb begin
    sr_next   = {sr_q[WIDTH-2:0], data_in};
    match     = (sr_next == COM);
    boundary  = (cnt_q == CntLast);
    state_d   = state_q;
    cnt_d     = boundary ? '0 : cnt_q + 1'b1;
    com_cnt_d = com_cnt_q;
    data_d    = data_q;
    valid_d   = 1'b0;

    unique case (state_q)
      StHunt: begin
        // A comma at any offset fixes the boundary: next bit is bit 0 of a word.
        if (match) begin
          cnt_d     = '0;
          com_cnt_d = ComW'(1);
          state_d   = (LOCK_COUNT == 1) ? StLocked : StAlign;
        end
      end
      StAlign: begin
        if (boundary) begin
          if (match) begin
            com_cnt_d = com_cnt_q + 1'b1;
            if (com_cnt_d == ComFull) state_d = StLocked;
          end else begin
            com_cnt_d = '0;
            state_d   = StHunt;
          end
        end
      end
      StLocked: begin
        if (boundary) begin
          if (!match) begin
            data_d  = sr_next;
            valid_d = 1'b1;
          end
        end
`ifdef SP_REALIGN_EN
        else if (match) begin
          cnt_d     = '0;
          com_cnt_d = ComW'(1);
          state_d   = (LOCK_COUNT == 1) ? StLocked : StAlign;
        end
`endif
      end
      default: begin
        state_d   = StHunt;
        com_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      state_q   <= StHunt;
      sr_q      <= '0;
      cnt_q     <= '0;
      com_cnt_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_next;
      cnt_q     <= cnt_d;
      com_cnt_q <= com_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      active_q  <= (state_d == StLocked);
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign active    = active_q;

endmodule

// File: tb/tb_serial_paralelo_param.sv
// Directed bench for serial_paralelo_param: default build plus a WIDTH=10 instance,
// with a queue of expected data words popped on every observed strobe.
module tb_serial_paralelo_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rst10 = 1'b0;
  logic       data_in = 1'b0;
  logic       data10 = 1'b0;
  logic [7:0] data_out;
  logic       valid_out, active;
  logic [9:0] data10_out;
  logic       valid10, active10;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  serial_paralelo_param dut (
    .clk_32f  (clk),
    .reset    (rst),
    .data_in  (data_in),
    .data_out (data_out),
    .valid_out(valid_out),
    .active   (active)
  );

  serial_paralelo_param #(
    .WIDTH     (10),
    .COM       (10'h17C),
    .LOCK_COUNT(1)
  ) dut10 (
    .clk_32f  (clk),
    .reset    (rst10),
    .data_in  (data10),
    .data_out (data10_out),
    .valid_out(valid10),
    .active   (active10)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Shift n bits MSB first; exp_mask marks the bits whose edge must strobe.
  task automatic drive(input logic [31:0] bits, input int n, input logic [31:0] exp_mask,
                       input bit sel, input string tag);
    logic [31:0] obs;
    logic        v;
    logic [15:0] d;
    obs = '0;
    for (int k = 0; k < n; k++) begin
      if (sel) data10 = bits[n-1-k];
      else     data_in = bits[n-1-k];
      @(posedge clk);
      #1;
      v = sel ? valid10 : valid_out;
      d = sel ? {6'b0, data10_out} : {8'b0, data_out};
      obs[n-1-k] = v;
      if (v) begin
        if (exp_q.size() == 0) chk({tag, "_unexpected_strobe"}, 32'(exp_q.size()), 1);
        else                   chk({tag, "_data"}, d, exp_q.pop_front());
      end
    end
    chk({tag, "_strobes"}, obs, exp_mask);
  endtask

  initial begin
    // Asynchronous reset, between clock edges
    #1;
    rst   = 1'b1;
    rst10 = 1'b1;
    #1;
    chk("rst_data", data_out, 0);
    chk("rst_valid", valid_out, 0);
    chk("rst_active", active, 0);
    chk("rst10_data", data10_out, 0);
    chk("rst10_valid", valid10, 0);
    chk("rst10_active", active10, 0);

    // WIDTH=10, LOCK_COUNT=1: one comma locks, next word strobes
    @(posedge clk);
    #1;
    rst10 = 1'b0;
    drive(32'h17C, 10, 0, 1'b1, "w10_com");
    chk("w10_active", active10, 1);
    exp_q.push_back(16'h2A5);
    drive(32'h2A5, 10, 32'h1, 1'b1, "w10_data");
    chk("w10_active_hold", active10, 1);
    rst10 = 1'b1;

    // Lock at an offset after three garbage bits
    rst = 1'b0;
    drive(32'b101, 3, 0, 1'b0, "garbage");
    for (int i = 0; i < 4; i++) begin
      drive(32'hBC, 8, 0, 1'b0, "lock_bc");
      chk("lock_active", active, (i == 3) ? 1 : 0);
    end
    exp_q.push_back(16'hA5);
    drive(32'hA5, 8, 32'h1, 1'b0, "a5");
    chk("a5_active", active, 1);

    // Idle comma between data words
    exp_q.push_back(16'h12);
    drive(32'h12, 8, 32'h1, 1'b0, "d12");
    drive(32'hBC, 8, 0, 1'b0, "idle_bc");
    chk("idle_hold", data_out, 8'h12);
    exp_q.push_back(16'h34);
    drive(32'h34, 8, 32'h1, 1'b0, "d34");
    chk("d34_out", data_out, 8'h34);

    // Reset mid-word while locked
    drive(32'b110, 3, 0, 1'b0, "pre_rst");
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_data", data_out, 0);
    chk("mid_rst_valid", valid_out, 0);
    chk("mid_rst_active", active, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Broken alignment falls back to hunting
    drive(32'hBC, 8, 0, 1'b0, "brk_bc0");
    drive(32'hBC, 8, 0, 1'b0, "brk_bc1");
    drive(32'h3C, 8, 0, 1'b0, "brk_3c");
    chk("brk_active", active, 0);
    for (int i = 0; i < 4; i++) begin
      drive(32'hBC, 8, 0, 1'b0, "relock_bc");
      chk("relock_active", active, (i == 3) ? 1 : 0);
    end

    // Two-bit slip while locked; the boundary word before the comma is 0x2F
`ifdef SP_REALIGN_EN
    exp_q.push_back(16'h2F);
    drive({22'b0, 2'b00, 8'hBC}, 10, 32'b100, 1'b0, "slip");
    chk("slip_active", active, 0);
    for (int i = 0; i < 3; i++) begin
      drive(32'hBC, 8, 0, 1'b0, "realign_bc");
      chk("realign_active", active, (i == 2) ? 1 : 0);
    end
`else
    for (int i = 0; i < 4; i++) exp_q.push_back(16'h2F);
    drive({22'b0, 2'b00, 8'hBC}, 10, 32'b100, 1'b0, "slip");
    chk("slip_active", active, 1);
    for (int i = 0; i < 3; i++) begin
      drive(32'hBC, 8, 32'b100, 1'b0, "slip_bc");
      chk("slip_bc_active", active, 1);
    end
`endif

    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
